// File: rtl/alu_seq.sv
// alu_seq: registered W-bit ALU with a valid/ready handshake on both sides.
// One op is executed per accepted transaction. Result and flags are held in
// registers until the consumer takes them. An optional iterative unsigned
// multiplier can be added.
//
// Build option: define ALU_SEQ_MUL_EN to enable the W-cycle shift-add multiply
// (op 1000). When it is undefined, op 1000 is treated as an illegal op and
// r_hi is always 0.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   in_valid / in_ready   input handshake; a, b, c_in and op are captured on accept
//   out_valid / out_ready output handshake; r, r_hi and the flags are valid
//                         while out_valid is high
//   r, r_hi               result, and the high half of the MUL product
//   zero, c_out, sign, ovf  registered result flags
module alu_seq #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  input  logic [3:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] r,
  output logic [W-1:0] r_hi,
  output logic         zero,
  output logic         c_out,
  output logic         sign,
  output logic         ovf
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_INC = 4'h2;
  localparam logic [3:0] OP_NEG = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0]  OP_MUL = 4'h8;
  localparam int unsigned CW     = $clog2(W);
  localparam int unsigned W2     = 2 * W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd2
  } state_t;
`endif

  state_t r_state;
  state_t w_state_nxt;
  state_t w_accept_state;

  logic         w_accept;
  logic         w_start_mul;
  logic [W-1:0] w_x;
  logic [W-1:0] w_y;
  logic         w_ci;
  logic         w_arith;
  logic [W:0]   w_sum;
  logic [W-1:0] w_res;
  logic         w_c;
  logic         w_ovf;

  // Handshake: can take a new op when idle, or when the held result leaves this cycle.
  assign in_ready  = !reset && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == S_DONE);

`ifdef ALU_SEQ_MUL_EN
  assign w_start_mul = (op == OP_MUL);
`else
  assign w_start_mul = 1'b0;
`endif

  // Single-cycle ALU: all arithmetic ops share one adder x + y + ci.
  always_comb begin
    w_x     = '0;
    w_y     = '0;
    w_ci    = 1'b0;
    w_arith = 1'b0;
    w_res   = '0;
    case (op)
      OP_ADD: begin w_x = a;  w_y = b;  w_ci = c_in; w_arith = 1'b1; end
      OP_SUB: begin w_x = a;  w_y = ~b; w_ci = 1'b1; w_arith = 1'b1; end
      OP_INC: begin w_x = a;  w_y = '0; w_ci = 1'b1; w_arith = 1'b1; end
      OP_NEG: begin w_x = '0; w_y = ~b; w_ci = 1'b1; w_arith = 1'b1; end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_NOT: w_res = ~a;
      default: w_res = '0;
    endcase
    if (w_arith) begin
      w_res = w_sum[W-1:0];
    end
  end

  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{W{1'b0}}, w_ci};
  assign w_c   = w_arith && w_sum[W];
  // Signed overflow: adder inputs agree in sign but the result does not.
  assign w_ovf = w_arith && (w_x[W-1] == w_y[W-1]) && (w_sum[W-1] != w_x[W-1]);

`ifdef ALU_SEQ_MUL_EN
  logic [W2-1:0] r_prod;
  logic [W-1:0]  r_mcand;
  logic [CW-1:0] r_cnt;
  logic [W:0]    w_madd;
  logic [W2-1:0] w_prod_nxt;

  // Shift-add step: the low half holds the remaining multiplier bits, and the
  // high half accumulates partial products. Shift right once per step.
  assign w_madd     = {1'b0, r_prod[W2-1:W]} + (r_prod[0] ? {1'b0, r_mcand} : {(W+1){1'b0}});
  assign w_prod_nxt = {w_madd, r_prod[W-1:1]};
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt    = r_state;
`ifdef ALU_SEQ_MUL_EN
    w_accept_state = w_start_mul ? S_BUSY : S_DONE;
`else
    w_accept_state = S_DONE;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_accept_state;
      end
`ifdef ALU_SEQ_MUL_EN
      S_BUSY: begin
        if (r_cnt == '0) w_state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        if (w_accept)       w_state_nxt = w_accept_state;
        else if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result and flag registers. They load only when a result completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r     <= '0;
      r_hi  <= '0;
      zero  <= 1'b0;
      c_out <= 1'b0;
      sign  <= 1'b0;
      ovf   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_prod  <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
`endif
    end else begin
      if (w_accept && !w_start_mul) begin
        r     <= w_res;
        r_hi  <= '0;
        zero  <= (w_res == '0);
        c_out <= w_c;
        sign  <= w_res[W-1];
        ovf   <= w_ovf;
      end
`ifdef ALU_SEQ_MUL_EN
      if (w_accept && w_start_mul) begin
        r_prod  <= {{W{1'b0}}, b};
        r_mcand <= a;
        r_cnt   <= CW'(W - 1);
      end else if (r_state == S_BUSY) begin
        r_prod <= w_prod_nxt;
        r_cnt  <= r_cnt - 1'b1;
        if (r_cnt == '0) begin
          r     <= w_prod_nxt[W-1:0];
          r_hi  <= w_prod_nxt[W2-1:W];
          zero  <= (w_prod_nxt == '0);
          c_out <= 1'b0;
          sign  <= w_prod_nxt[W-1];
          ovf   <= (w_prod_nxt[W2-1:W] != '0);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (W=4): directed table, handshake corner
// sequences, and random transactions against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 4;
  localparam int M = 16;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r;
  logic [W-1:0] r_hi;
  logic         zero;
  logic         c_out;
  logic         sign;
  logic         ovf;

  alu_seq #(.W(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .r(r), .r_hi(r_hi), .zero(zero), .c_out(c_out),
    .sign(sign), .ovf(ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0] r_hi;
    logic [3:0] r;
    logic       zero;
    logic       c_out;
    logic       sign;
    logic       ovf;
  } res_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [3:0] op;
    res_t       e;
    int         lat;
  } vec_t;

`ifdef ALU_SEQ_MUL_EN
  localparam int MUL_LAT = W + 1;
`else
  localparam int MUL_LAT = 1;
`endif

  int   n_chk;
  int   n_pass;
  vec_t vt[24];
  int   nv;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h", nm, act, exp);
  endfunction

  function automatic res_t dut_res();
    res_t x;
    x.r_hi = r_hi; x.r = r; x.zero = zero; x.c_out = c_out; x.sign = sign; x.ovf = ovf;
    return x;
  endfunction

  function automatic int sval(int u);
    return (u >= M / 2) ? u - M : u;
  endfunction

  // Reference model: true unsigned and signed results, reduced to W bits.
  function automatic res_t model(int ua, int ub, int uc, int uop);
    res_t m;
    int   s;
    int   sv;
    int   lo;
    int   hi;
    bit   arith;
    arith = 1'b1;
    s = 0; sv = 0; hi = 0;
    case (uop)
      0: begin s = ua + ub + uc; sv = sval(ua) + sval(ub) + uc; end
      1: begin s = ua - ub + M;  sv = sval(ua) - sval(ub); end
      2: begin s = ua + 1;       sv = sval(ua) + 1; end
      3: begin s = M - ub;       sv = -sval(ub); end
      default: arith = 1'b0;
    endcase
    m = '0;
    if (arith) begin
      lo = s % M;
      m.c_out = (s >= M);
      m.ovf   = (sv > M / 2 - 1) || (sv < -(M / 2));
    end else begin
      case (uop)
        4: lo = ua & ub;
        5: lo = ua | ub;
        6: lo = ua ^ ub;
        7: lo = (M - 1) - ua;
`ifdef ALU_SEQ_MUL_EN
        8: begin lo = (ua * ub) % M; hi = (ua * ub) / M; m.ovf = (hi != 0); end
`endif
        default: lo = 0;
      endcase
    end
    m.r    = 4'(lo);
    m.r_hi = 4'(hi);
    m.zero = (lo == 0) && (hi == 0);
    m.sign = (lo >= M / 2);
    return m;
  endfunction

  function automatic void add_vec(logic [3:0] va, logic [3:0] vb, logic vc, logic [3:0] vop,
                                  logic [3:0] eh, logic [3:0] er, logic ez, logic ec,
                                  logic es, logic eo, int el);
    vt[nv].a = va; vt[nv].b = vb; vt[nv].c = vc; vt[nv].op = vop;
    vt[nv].e.r_hi = eh; vt[nv].e.r = er; vt[nv].e.zero = ez; vt[nv].e.c_out = ec;
    vt[nv].e.sign = es; vt[nv].e.ovf = eo; vt[nv].lat = el;
    nv++;
  endfunction

  // Issue one transaction from IDLE, wait for its result, check it, then retire it.
  // Called at posedge+1 with out_ready low.
  task automatic run_txn(input logic [3:0] ta, input logic [3:0] tb2, input logic tc,
                         input logic [3:0] top, input res_t e, input int elat,
                         input string nm, input int hold);
    int   lat;
    logic rdy_busy;
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb2; c_in = tc; op = top; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 4'($urandom); b = 4'($urandom); c_in = 1'($urandom); op = 4'($urandom);
    lat = 1;
    rdy_busy = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_busy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(elat));
    chk({nm, "_result"}, 32'(dut_res()), 32'(e));
    if (elat > 1) chk({nm, "_ready_while_busy"}, 32'(rdy_busy), 32'd0);
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_retired"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    res_t e;
    logic seen;
    n_chk = 0; n_pass = 0; nv = 0;
    in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; op = '0; out_ready = 1'b0;
    reset = 1'b0;
    #2 reset = 1'b1;

    // Directed table: {a, b, c_in, op} -> {r_hi, r, zero, c_out, sign, ovf}, latency
    add_vec(4'h7, 4'h9, 1'b0, 4'h0, 4'h0, 4'h0, 1, 1, 0, 0, 1);  // ADD wrap to 0
    add_vec(4'h7, 4'h1, 1'b0, 4'h0, 4'h0, 4'h8, 0, 0, 1, 1, 1);  // ADD signed ovf
    add_vec(4'h3, 4'h5, 1'b0, 4'h1, 4'h0, 4'hE, 0, 0, 1, 0, 1);  // SUB borrow
    add_vec(4'hA, 4'hF, 1'b1, 4'h6, 4'h0, 4'h5, 0, 0, 0, 0, 1);  // XOR
    add_vec(4'hF, 4'h3, 1'b0, 4'h7, 4'h0, 4'h0, 1, 0, 0, 0, 1);  // NOT
    add_vec(4'h0, 4'h1, 1'b0, 4'h3, 4'h0, 4'hF, 0, 0, 1, 0, 1);  // NEG 1
    add_vec(4'h3, 4'h4, 1'b1, 4'hB, 4'h0, 4'h0, 1, 0, 0, 0, 1);  // illegal op
    add_vec(4'h5, 4'h6, 1'b1, 4'h0, 4'h0, 4'hC, 0, 0, 1, 1, 1);  // ADD with c_in
    add_vec(4'h5, 4'h5, 1'b0, 4'h1, 4'h0, 4'h0, 1, 1, 0, 0, 1);  // SUB equal, no borrow
    add_vec(4'hF, 4'h0, 1'b1, 4'h2, 4'h0, 4'h0, 1, 1, 0, 0, 1);  // INC wrap
    add_vec(4'hC, 4'hA, 1'b0, 4'h4, 4'h0, 4'h8, 0, 0, 1, 0, 1);  // AND
    add_vec(4'h5, 4'hA, 1'b0, 4'h5, 4'h0, 4'hF, 0, 0, 1, 0, 1);  // OR
    add_vec(4'h0, 4'h8, 1'b0, 4'h3, 4'h0, 4'h8, 0, 0, 1, 1, 1);  // NEG most negative
    add_vec(4'h0, 4'h0, 1'b0, 4'h3, 4'h0, 4'h0, 1, 1, 0, 0, 1);  // NEG 0
    add_vec(4'h7, 4'h7, 1'b1, 4'hF, 4'h0, 4'h0, 1, 0, 0, 0, 1);  // illegal op 1111
`ifdef ALU_SEQ_MUL_EN
    add_vec(4'hF, 4'hF, 1'b0, 4'h8, 4'hE, 4'h1, 0, 0, 0, 1, W + 1);
    add_vec(4'h3, 4'h5, 1'b0, 4'h8, 4'h0, 4'hF, 0, 0, 1, 0, W + 1);
    add_vec(4'h0, 4'h9, 1'b0, 4'h8, 4'h0, 4'h0, 1, 0, 0, 0, W + 1);
`else
    add_vec(4'hF, 4'hF, 1'b0, 4'h8, 4'h0, 4'h0, 1, 0, 0, 0, 1);
`endif

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", 32'({out_valid, in_ready, dut_res()}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("reset_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < nv; i++) begin
      run_txn(vt[i].a, vt[i].b, vt[i].c, vt[i].op, vt[i].e, vt[i].lat,
              $sformatf("vec%0d", i), i % 3);
    end

    // Backpressure: the result stays put while out_ready is low.
    e = model(7, 1, 0, 0);
    a = 4'h7; b = 4'h1; c_in = 1'b0; op = 4'h0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d", i), 32'({out_valid, in_ready, dut_res()}),
          32'({1'b1, 1'b0, e}));
      @(posedge clk); #1;
    end
    // Retire and accept a new op in the same cycle.
    out_ready = 1'b1; in_valid = 1'b1; a = 4'hF; b = 4'h2; op = 4'h2;
    #1 chk("bp_same_cycle_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bp_inc_result", 32'({out_valid, dut_res()}), 32'({1'b1, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0}));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset asserted two cycles into a MUL.
    run_txn(4'h7, 4'h1, 1'b0, 4'h0, model(7, 1, 0, 0), 1, "pre_reset", 0);
    a = 4'hF; b = 4'hF; op = 4'h8; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1 chk("mid_mul_reset", 32'({out_valid, in_ready, dut_res()}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1 chk("post_reset_ready", 32'({in_ready, out_valid}), 32'b10);
    seen = 1'b0;
    repeat (2 * W + 2) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("post_reset_no_valid", 32'(seen), 32'd0);
    run_txn(4'hF, 4'hF, 1'b0, 4'h8, model(15, 15, 0, 8), MUL_LAT, "post_reset_mul", 0);

    // Random transactions against the model
    for (int i = 0; i < 150; i++) begin
      logic [3:0] ra;
      logic [3:0] rb;
      logic       rc;
      logic [3:0] rop;
      ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom);
      rop = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 8));
      run_txn(ra, rb, rc, rop, model(int'(ra), int'(rb), int'(rc), int'(rop)),
              (rop == 4'h8) ? MUL_LAT : 1, $sformatf("rnd%0d", i), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
